parity_unit: RTL and testbench

Registered parity generator/checker for a BW_DATA-bit data word. Each accepted word gets an even or odd parity bit, selected per word, one clock after acceptance. An optional check path compares a received parity bit against the computed one, flags mismatches, and counts them in a saturating error counter. It sits beside a datapath register stage, either to protect outgoing words or to verify incoming ones.

---
 rtl/parity_unit.sv | 67 ++++++
 tb/tb_parity_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/parity_unit.sv
// Registered parity generator/checker with a saturating mismatch counter.
// Every output comes straight from a flop; one cycle of latency.
module parity_unit #(
    parameter int BW_DATA = 8,
    parameter int BW_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [BW_DATA-1:0] i_A,
    input  logic               i_vld,
    input  logic               i_odd,
    input  logic               i_chk,
    input  logic               i_par,
    input  logic               i_clr,
    output logic               o_Y,
    output logic               o_vld,
    output logic               o_err,
    output logic [BW_CNT-1:0]  o_err_cnt
);

    logic              par_c;
    logic              mis_c;
    logic              y_d,   y_q;
    logic              vld_d, vld_q;
    logic              err_d, err_q;
    logic [BW_CNT-1:0] cnt_d, cnt_q;

    // Parity and mismatch detection; y holds when no word is accepted.
    always_comb begin
        par_c = (^i_A) ^ i_odd;
        mis_c = i_vld & i_chk & (i_par != par_c);
        y_d   = i_vld ? par_c : y_q;
        vld_d = i_vld;
        err_d = mis_c;
    end

    // Error counter: clear beats a same-edge mismatch; saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (mis_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + BW_CNT'(1);
        end
    end

    // Output registers, cleared immediately by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            y_q   <= 1'b0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_Y       = y_q;
    assign o_vld     = vld_q;
    assign o_err     = err_q;
    assign o_err_cnt = cnt_q;

endmodule

// File: tb/tb_parity_unit.sv
// Self-checking bench for parity_unit: directed cases plus random words
// against a ones-count reference model; a BW_CNT=2 twin checks saturation.
module tb_parity_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  a = '0;
    logic        vld = 1'b0;
    logic        odd = 1'b0;
    logic        ck = 1'b0;
    logic        par = 1'b0;
    logic        clr = 1'b0;
    logic        y, ovld, oerr;
    logic [15:0] cnt;
    logic        y2, ovld2, oerr2;
    logic [1:0]  cnt2;

    int n_vec = 0;
    int n_err = 0;

    int m_y = 0, m_vld = 0, m_err = 0;
    int m_cnt = 0, m_cnt2 = 0;

    always #5 clk = ~clk;

    parity_unit #(.BW_DATA(8), .BW_CNT(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_A(a), .i_vld(vld),
        .i_odd(odd), .i_chk(ck), .i_par(par), .i_clr(clr),
        .o_Y(y), .o_vld(ovld), .o_err(oerr), .o_err_cnt(cnt)
    );

    parity_unit #(.BW_DATA(8), .BW_CNT(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_A(a), .i_vld(vld),
        .i_odd(odd), .i_chk(ck), .i_par(par), .i_clr(clr),
        .o_Y(y2), .o_vld(ovld2), .o_err(oerr2), .o_err_cnt(cnt2)
    );

    task automatic expect_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        expect_eq({tag, ".y"}, int'(y), m_y);
        expect_eq({tag, ".vld"}, int'(ovld), m_vld);
        expect_eq({tag, ".err"}, int'(oerr), m_err);
        expect_eq({tag, ".cnt"}, int'(cnt), m_cnt);
        expect_eq({tag, ".y2"}, int'(y2), m_y);
        expect_eq({tag, ".err2"}, int'(oerr2), m_err);
        expect_eq({tag, ".cnt2"}, int'(cnt2), m_cnt2);
    endtask

    task automatic model_reset();
        m_y = 0; m_vld = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    // Drive one cycle, advance the model by the parity rules, check outputs.
    task automatic apply(input string tag, input logic v, input logic [7:0] d,
                         input logic o, input logic c, input logic p,
                         input logic cl);
        int ones, exp_p, mis;
        @(negedge clk);
        vld = v; a = d; odd = o; ck = c; par = p; clr = cl;
        @(posedge clk);
        ones = $countones(d);
        // Choose p so that ones(d)+p is even (even mode) or odd (odd mode).
        exp_p = (o == 1'b0) ? (ones % 2) : ((ones + 1) % 2);
        mis = (v && c && (int'(p) != exp_p)) ? 1 : 0;
        if (v) m_y = exp_p;
        m_vld = v ? 1 : 0;
        m_err = mis;
        if (cl) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (mis != 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check_all("por");
        repeat (2) @(posedge clk);
        #1;
        check_all("por_hold");
        @(negedge clk);
        rst = 1'b0;

        // Generation
        apply("g_a5_even", 1, 8'hA5, 0, 0, 0, 0);
        expect_eq("g_a5_even.lit", int'(y), 0);
        apply("g_a5_odd", 1, 8'hA5, 1, 0, 0, 0);
        expect_eq("g_a5_odd.lit", int'(y), 1);
        apply("g_00_odd", 1, 8'h00, 1, 0, 0, 0);
        expect_eq("g_00_odd.lit", int'(y), 1);
        apply("g_07_even", 1, 8'h07, 0, 0, 0, 0);
        expect_eq("g_07_even.lit", int'(y), 1);

        // Hold
        apply("hold", 0, 8'h00, 0, 1, 0, 0);
        expect_eq("hold.lit_y", int'(y), 1);
        expect_eq("hold.lit_vld", int'(ovld), 0);

        // Check path
        apply("chk_bad", 1, 8'h01, 0, 1, 0, 0);
        expect_eq("chk_bad.lit_err", int'(oerr), 1);
        expect_eq("chk_bad.lit_cnt", int'(cnt), 1);
        apply("chk_ok", 1, 8'h01, 0, 1, 1, 0);
        expect_eq("chk_ok.lit_err", int'(oerr), 0);
        expect_eq("chk_ok.lit_cnt", int'(cnt), 1);
        apply("chk_off", 1, 8'h01, 0, 0, 0, 0);
        expect_eq("chk_off.lit_cnt", int'(cnt), 1);

        // Saturation on the 2-bit twin
        apply("sat_clr", 0, 8'h00, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            apply("sat", 1, 8'h01, 0, 1, 0, 0);
            expect_eq("sat.lit_cnt2", int'(cnt2), (i < 3) ? i + 1 : 3);
        end
        apply("clr_mis", 1, 8'h01, 0, 1, 0, 1);
        expect_eq("clr_mis.lit_cnt2", int'(cnt2), 0);
        expect_eq("clr_mis.lit_err", int'(oerr), 1);

        // Random back-to-back traffic
        for (int i = 0; i < 100; i++) begin
            apply("rnd_gen", 1, 8'($urandom), 1'($urandom), 0, 0, 0);
        end
        for (int i = 0; i < 200; i++) begin
            apply("rnd_mix", ($urandom_range(0, 5) != 0), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 30) == 0));
        end

        // Reset mid-stream, asserted between edges
        @(negedge clk);
        vld = 1'b1; a = 8'hFF; odd = 1'b1; ck = 1'b1; par = 1'b1;
        clr = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst", 1, 8'h03, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
